systolic_feed_controller: RTL and testbench
===========================================

Name: systolic_feed_controller

Overview:
- Sequencer for the N x N output-stationary systolic MAC array.
- Accepts one A/B operand job over a valid/ready handshake and pulses the accumulator clear.
- Drives skewed A columns and B rows for 2N-1 feed steps, then holds zero operands while the array drains.
- Captures the array's accumulator bank and presents the result over a valid/ready handshake. Sits between the job source (host/DMA side) and the array.

Parameters:
- OP_WIDTH, 8, operand element width (bits).
- ACC_WIDTH, 18, accumulator/result element width (bits).
- N, 2, array dimension; legal range 2..8.
- ARRAY_LAT, 1, register stages from the array operand inputs to a settled accumulator update.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  job source offers A/B.
- in_ready  out  1  controller accepts a job.
- A  in  N*N*OP_WIDTH  row-major; element (r,c) at [(r*N+c)*OP_WIDTH +: OP_WIDTH].
- B  in  N*N*OP_WIDTH  same packing as A.
- abort  in  1  synchronous cancel of the current job.
- acc_clear  out  1  one-cycle clear of all array accumulators.
- mac_en  out  1  array enable.
- a_col  out  N*OP_WIDTH  lane i at [i*OP_WIDTH +: OP_WIDTH], feeds array row i.
- b_row  out  N*OP_WIDTH  lane j feeds array column j.
- c_in  in  N*N*ACC_WIDTH  array accumulator bank, row-major.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- C  out  N*N*ACC_WIDTH  registered result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, step counter=0, A/B/C registers=0, all outputs 0 except in_ready=1.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A and B, go to CLEAR.
  - Later changes on the A/B inputs have no effect on the running job.
- CLEAR (1 cycle): acc_clear=1, mac_en=0, operands 0. Go to FEED with k=0.
- FEED (2N-1 cycles, k=0..2N-2):
  - mac_en=1.
  - a_col lane i = A(i, k-i) if 0 <= k-i < N, else 0.
  - b_row lane j = B(k-j, j) if 0 <= k-j < N, else 0.
  - After k=2N-2, go to DRAIN.
- DRAIN (N-1+ARRAY_LAT cycles): mac_en=1, a_col=b_row=0. On the last DRAIN cycle's edge, C <= c_in, then go to DONE.
- DONE:
  - res_valid=1; C stable.
  - On res_ready, go to IDLE next cycle.
  - res_valid drops with the handshake; in_ready rises the cycle after, so there is no same-cycle result-and-accept.
- Latency: accept edge to res_valid high = 1 + (2N-1) + (N-1+ARRAY_LAT) cycles; 6 for N=2, ARRAY_LAT=1.
- in_valid while not IDLE: ignored, since in_ready=0.
- abort:
  - In CLEAR/FEED/DRAIN: next state IDLE, mac_en=0, operands 0, C unchanged, no res_valid.
  - In IDLE/DONE: no effect.
  - abort coincident with the capture edge: the abort wins; no capture.
- Wrap-around: the step counter holds width clog2(2N) and is cleared on entry to FEED and DRAIN. No unsigned k-i underflow aliasing: compare before subtracting.
- Reset asserted mid-job: immediate return to reset values; the job is lost.
- busy=1 in CLEAR, FEED, DRAIN and DONE.

Test Plan:
- Basic job, N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], bench array model:
  - Feed, packed {lane1,lane0}: k0 a={0,1} b={0,5}; k1 a={3,2} b={6,7}; k2 a={4,0} b={8,0}.
  - acc_clear exactly 1 cycle before k0.
  - res_valid 6 cycles after accept; C=[[19,22],[43,50]].
- Backpressure: hold res_ready=0 for 10 cycles.
  - res_valid and C stay stable; in_ready stays 0.
  - A second in_valid is not accepted until 1 cycle after the res_ready handshake.
- Operand change after accept: drive A=all 0xFF the cycle after the handshake. Feed still uses the latched values; C still equals [[19,22],[43,50]].
- Abort at FEED k=1:
  - The next cycle is IDLE with mac_en=0 and no res_valid.
  - C keeps its previous value.
  - A new job afterwards completes correctly, including its acc_clear.
- Async reset pulse during DRAIN: outputs go to reset values without waiting for a clock edge, with in_ready=1.
- N=3, ARRAY_LAT=2, A=identity, B=[[1..9]]:
  - 5 feed steps with the correct zero-padded skew.
  - res_valid 1+5+4=10 cycles after accept; C=B.

Source files
------------

// File: rtl/systolic_feed_controller.sv
// Sequencer for an N x N output-stationary systolic MAC array.
// Latches one A/B job, clears the accumulators, feeds skewed operands for 2N-1 steps,
// drains the array, then captures and holds the accumulator bank until the consumer takes it.
module systolic_feed_controller #(
    parameter int unsigned OP_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH = 18,
    parameter int unsigned N         = 2,
    parameter int unsigned ARRAY_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*N*OP_WIDTH-1:0]      A,
    input  logic [N*N*OP_WIDTH-1:0]      B,
    input  logic                         abort,
    output logic                         acc_clear,
    output logic                         mac_en,
    output logic [N*OP_WIDTH-1:0]        a_col,
    output logic [N*OP_WIDTH-1:0]        b_row,
    input  logic [N*N*ACC_WIDTH-1:0]     c_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [N*N*ACC_WIDTH-1:0]     C,
    output logic                         busy
);

    localparam int unsigned FeedLen   = 2 * N - 1;
    localparam int unsigned DrainLen  = N - 1 + ARRAY_LAT;
    localparam int unsigned CntWFeed  = $clog2(2 * N);
    localparam int unsigned CntWDrain = $clog2(DrainLen + 1);
    // Counter must cover both the feed and the drain phase.
    localparam int unsigned CntW      = (CntWFeed > CntWDrain) ? CntWFeed : CntWDrain;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            k_q, k_d;
    logic [N*N*OP_WIDTH-1:0]    a_q, a_d;
    logic [N*N*OP_WIDTH-1:0]    b_q, b_d;
    logic [N*N*ACC_WIDTH-1:0]   c_q, c_d;
    logic                       feed_en;
    int                         k_int;

    assign k_int = int'(k_q);

    // State, step counter, latched operands and captured result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    // Next-state: job accept, phase sequencing, abort and result capture.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    state_d = StFeed;
                    k_d     = '0;
                end
            end
            StFeed: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (k_q == CntW'(FeedLen - 1)) begin
                    state_d = StDrain;
                    k_d     = '0;
                end else begin
                    k_d = k_q + CntW'(1);
                end
            end
            StDrain: begin
                // Abort on the capture edge wins: the old result is kept.
                if (abort) begin
                    state_d = StIdle;
                end else if (k_q == CntW'(DrainLen - 1)) begin
                    c_d     = c_in;
                    state_d = StDone;
                end else begin
                    k_d = k_q + CntW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: handshakes, array control and the skewed operand lanes.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        acc_clear = (state_q == StClear);
        res_valid = (state_q == StDone);
        mac_en    = ((state_q == StFeed) || (state_q == StDrain)) && !abort;
        feed_en   = (state_q == StFeed) && !abort;
        a_col     = '0;
        b_row     = '0;
        // Compare before subtracting so k-i never wraps.
        for (int i = 0; i < int'(N); i++) begin
            if (feed_en && (k_int >= i) && (k_int - i < int'(N))) begin
                a_col[i*OP_WIDTH +: OP_WIDTH] =
                    a_q[(i * int'(N) + (k_int - i)) * OP_WIDTH +: OP_WIDTH];
                b_row[i*OP_WIDTH +: OP_WIDTH] =
                    b_q[((k_int - i) * int'(N) + i) * OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    assign C = c_q;

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Bench for systolic_feed_controller: two instances (N=2/LAT=1 and N=3/LAT=2), each driving a
// behavioural systolic array, checked every cycle against a timeline model plus literal vectors.
module tb_systolic_feed_controller;

    localparam int W  = 8;
    localparam int AW = 18;

    logic clk;
    logic rst_n;
    logic iv[2];
    logic rr[2];
    logic ab[2];

    int ain[2][3][3];
    int bin[2][3][3];

    logic [4*W-1:0]  a0, b0;
    logic [9*W-1:0]  a1, b1;
    logic [4*AW-1:0] cin0, cq0;
    logic [9*AW-1:0] cin1, cq1;
    logic [2*W-1:0]  acol0, brow0;
    logic [3*W-1:0]  acol1, brow1;
    logic in_ready0, acc_clear0, mac_en0, res_valid0, busy0;
    logic in_ready1, acc_clear1, mac_en1, res_valid1, busy1;

    // Generic per-instance views of the DUT outputs
    int   acol_v[2][3];
    int   brow_v[2][3];
    int   cq_v[2][3][3];
    logic mac_v[2], clr_v[2], ir_v[2], rv_v[2], busy_v[2];

    // Array model state
    int acc[2][3][3];
    int acc_d[2][3][3];
    int ah[2][3][3];
    int bh[2][3][3];

    // Expected-behaviour model state
    int t[2];
    int ma[2][3][3];
    int mb[2][3][3];
    int mc[2][3][3];

    int n_cmp;
    int n_err;
    int lat;

    systolic_feed_controller #(.OP_WIDTH(W), .ACC_WIDTH(AW), .N(2), .ARRAY_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(in_ready0), .A(a0), .B(b0),
        .abort(ab[0]), .acc_clear(acc_clear0), .mac_en(mac_en0), .a_col(acol0), .b_row(brow0),
        .c_in(cin0), .res_valid(res_valid0), .res_ready(rr[0]), .C(cq0), .busy(busy0)
    );

    systolic_feed_controller #(.OP_WIDTH(W), .ACC_WIDTH(AW), .N(3), .ARRAY_LAT(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(in_ready1), .A(a1), .B(b1),
        .abort(ab[1]), .acc_clear(acc_clear1), .mac_en(mac_en1), .a_col(acol1), .b_row(brow1),
        .c_in(cin1), .res_valid(res_valid1), .res_ready(rr[1]), .C(cq1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nv(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int alv(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Pack bench matrices onto the operand ports
    always_comb begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                a0[(r*2+c)*W +: W] = 8'(ain[0][r][c]);
                b0[(r*2+c)*W +: W] = 8'(bin[0][r][c]);
            end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                a1[(r*3+c)*W +: W] = 8'(ain[1][r][c]);
                b1[(r*3+c)*W +: W] = 8'(bin[1][r][c]);
            end
    end

    // Unpack DUT outputs into generic views
    always_comb begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 3; i++) begin
                acol_v[d][i] = 0;
                brow_v[d][i] = 0;
                for (int j = 0; j < 3; j++) cq_v[d][i][j] = 0;
            end
        for (int i = 0; i < 2; i++) begin
            acol_v[0][i] = int'(acol0[i*W +: W]);
            brow_v[0][i] = int'(brow0[i*W +: W]);
            for (int j = 0; j < 2; j++) cq_v[0][i][j] = int'(cq0[(i*2+j)*AW +: AW]);
        end
        for (int i = 0; i < 3; i++) begin
            acol_v[1][i] = int'(acol1[i*W +: W]);
            brow_v[1][i] = int'(brow1[i*W +: W]);
            for (int j = 0; j < 3; j++) cq_v[1][i][j] = int'(cq1[(i*3+j)*AW +: AW]);
        end
        mac_v[0] = mac_en0;    mac_v[1] = mac_en1;
        clr_v[0] = acc_clear0; clr_v[1] = acc_clear1;
        ir_v[0]  = in_ready0;  ir_v[1]  = in_ready1;
        rv_v[0]  = res_valid0; rv_v[1]  = res_valid1;
        busy_v[0] = busy0;     busy_v[1] = busy1;
    end

    // Array accumulator bank onto c_in (LAT=2 adds one output register)
    always_comb begin
        cin0 = '0;
        cin1 = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) cin0[(i*2+j)*AW +: AW] = AW'(acc[0][i][j]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) cin1[(i*3+j)*AW +: AW] = AW'(acc_d[1][i][j]);
    end

    // Product seen by PE(i,j): a lane i delayed j cycles, b lane j delayed i cycles
    function automatic int pe_prod(input int d, input int i, input int j);
        int av;
        int bv;
        av = (j == 0) ? acol_v[d][i] : ah[d][j][i];
        bv = (i == 0) ? brow_v[d][j] : bh[d][i][j];
        return av * bv;
    endfunction

    // Behavioural output-stationary systolic array
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        acc[d][i][j]   <= 0;
                        acc_d[d][i][j] <= 0;
                        ah[d][i][j]    <= 0;
                        bh[d][i][j]    <= 0;
                    end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < nv(d); i++)
                    for (int j = 0; j < nv(d); j++) begin
                        acc_d[d][i][j] <= acc[d][i][j];
                        if (clr_v[d]) acc[d][i][j] <= 0;
                        else if (mac_v[d]) acc[d][i][j] <= acc[d][i][j] + pe_prod(d, i, j);
                    end
                for (int i = 0; i < 3; i++) begin
                    ah[d][2][i] <= ah[d][1][i];
                    ah[d][1][i] <= acol_v[d][i];
                    bh[d][2][i] <= bh[d][1][i];
                    bh[d][1][i] <= brow_v[d][i];
                end
            end
        end
    end

    function automatic int matmul(input int d, input int i, input int j);
        int s;
        s = 0;
        for (int k = 0; k < nv(d); k++) s += ma[d][i][k] * mb[d][k][j];
        return s % (1 << AW);
    endfunction

    // Timeline model: t = cycles since accept; 1 clear, 2..2N feed, then N-1+LAT drain, then done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                t[d] <= 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        ma[d][i][j] <= 0;
                        mb[d][i][j] <= 0;
                        mc[d][i][j] <= 0;
                    end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (t[d] == 0) begin
                    if (iv[d]) begin
                        ma[d] <= ain[d];
                        mb[d] <= bin[d];
                        t[d]  <= 1;
                    end
                end else if (t[d] <= 3 * nv(d) - 1 + alv(d)) begin
                    if (ab[d]) begin
                        t[d] <= 0;
                    end else begin
                        if (t[d] == 3 * nv(d) - 1 + alv(d))
                            for (int i = 0; i < nv(d); i++)
                                for (int j = 0; j < nv(d); j++) mc[d][i][j] <= matmul(d, i, j);
                        t[d] <= t[d] + 1;
                    end
                end else if (rr[d]) begin
                    t[d] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every instance against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                int n;
                int tt;
                int dend;
                int k;
                bit feed;
                int ea;
                int eb;
                n    = nv(d);
                tt   = t[d];
                dend = 3 * n - 1 + alv(d);
                k    = tt - 2;
                feed = (tt >= 2) && (tt <= 2 * n) && !ab[d];
                chk($sformatf("d%0d in_ready", d), longint'(ir_v[d]), longint'(tt == 0));
                chk($sformatf("d%0d busy", d), longint'(busy_v[d]), longint'(tt != 0));
                chk($sformatf("d%0d acc_clear", d), longint'(clr_v[d]), longint'(tt == 1));
                chk($sformatf("d%0d mac_en", d), longint'(mac_v[d]),
                    longint'((tt >= 2) && (tt <= dend) && !ab[d]));
                chk($sformatf("d%0d res_valid", d), longint'(rv_v[d]), longint'(tt > dend));
                for (int i = 0; i < n; i++) begin
                    ea = 0;
                    eb = 0;
                    if (feed && k >= i && k - i < n) begin
                        ea = ma[d][i][k-i];
                        eb = mb[d][k-i][i];
                    end
                    chk($sformatf("d%0d a_col[%0d]", d, i), acol_v[d][i], ea);
                    chk($sformatf("d%0d b_row[%0d]", d, i), brow_v[d][i], eb);
                    for (int j = 0; j < n; j++)
                        chk($sformatf("d%0d C[%0d][%0d]", d, i, j), cq_v[d][i][j], mc[d][i][j]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mat2(input int d, input int m00, input int m01, input int m10,
                            input int m11, input bit is_b);
        if (is_b) begin
            bin[d][0][0] = m00; bin[d][0][1] = m01; bin[d][1][0] = m10; bin[d][1][1] = m11;
        end else begin
            ain[d][0][0] = m00; ain[d][0][1] = m01; ain[d][1][0] = m10; ain[d][1][1] = m11;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; rr[d] = 1'b0; ab[d] = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    ain[d][i][j] = 0;
                    bin[d][i][j] = 0;
                end
        end
        #2;
        chk("reset in_ready", longint'(in_ready0), 1);
        chk("reset busy", longint'(busy0), 0);
        chk("reset res_valid", longint'(res_valid0), 0);
        chk("reset C", longint'(cq0), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic job; operands are overwritten right after the handshake
        set_mat2(0, 1, 2, 3, 4, 0);
        set_mat2(0, 5, 6, 7, 8, 1);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        set_mat2(0, 255, 255, 255, 255, 0);
        chk("job1 acc_clear", longint'(acc_clear0), 1);
        chk("job1 clear mac_en", longint'(mac_en0), 0);
        tick();
        chk("job1 k0 a_col", longint'(acol0), 64'h0001);
        chk("job1 k0 b_row", longint'(brow0), 64'h0005);
        chk("job1 k0 acc_clear", longint'(acc_clear0), 0);
        tick();
        chk("job1 k1 a_col", longint'(acol0), 64'h0302);
        chk("job1 k1 b_row", longint'(brow0), 64'h0607);
        tick();
        chk("job1 k2 a_col", longint'(acol0), 64'h0400);
        chk("job1 k2 b_row", longint'(brow0), 64'h0800);
        lat = 3;
        for (int w = 0; w < 20 && !res_valid0; w++) begin
            tick();
            lat++;
        end
        chk("job1 latency", lat, 6);
        chk("job1 C00", longint'(cq0[0*AW +: AW]), 19);
        chk("job1 C01", longint'(cq0[1*AW +: AW]), 22);
        chk("job1 C10", longint'(cq0[2*AW +: AW]), 43);
        chk("job1 C11", longint'(cq0[3*AW +: AW]), 50);
        chk("model C11", mc[0][1][1], 50);

        // Backpressure with a second job already offered
        set_mat2(0, 9, 9, 9, 9, 0);
        set_mat2(0, 9, 9, 9, 9, 1);
        iv[0] = 1'b1;
        for (int w = 0; w < 10; w++) begin
            tick();
            chk("bp in_ready", longint'(in_ready0), 0);
            chk("bp res_valid", longint'(res_valid0), 1);
            chk("bp C00", longint'(cq0[0*AW +: AW]), 19);
        end
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;
        chk("hs res_valid", longint'(res_valid0), 0);
        chk("hs in_ready", longint'(in_ready0), 1);
        tick();
        iv[0] = 1'b0;
        chk("job2 accepted", longint'(acc_clear0), 1);

        // Abort at feed step k=1
        tick();
        tick();
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abort mac_en", longint'(mac_en0), 0);
        chk("abort res_valid", longint'(res_valid0), 0);
        chk("abort in_ready", longint'(in_ready0), 1);
        chk("abort C00", longint'(cq0[0*AW +: AW]), 19);
        chk("abort C11", longint'(cq0[3*AW +: AW]), 50);

        // Fresh job after abort: stale partial sums must be cleared
        set_mat2(0, 2, 0, 1, 3, 0);
        set_mat2(0, 1, 1, 2, 2, 1);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        lat = 0;
        for (int w = 0; w < 20 && !res_valid0; w++) begin
            tick();
            lat++;
        end
        chk("job3 latency", lat, 6);
        chk("job3 C00", longint'(cq0[0*AW +: AW]), 2);
        chk("job3 C01", longint'(cq0[1*AW +: AW]), 2);
        chk("job3 C10", longint'(cq0[2*AW +: AW]), 7);
        chk("job3 C11", longint'(cq0[3*AW +: AW]), 7);
        rr[0] = 1'b1;
        tick();
        rr[0] = 1'b0;

        // Asynchronous reset in the first drain cycle
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        chk("drain mac_en", longint'(mac_en0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async in_ready", longint'(in_ready0), 1);
        chk("async busy", longint'(busy0), 0);
        chk("async mac_en", longint'(mac_en0), 0);
        chk("async C", longint'(cq0), 0);
        #1 rst_n = 1'b1;
        tick();
        tick();

        // N=3, LAT=2: identity times B
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ain[1][i][j] = (i == j) ? 1 : 0;
                bin[1][i][j] = i * 3 + j + 1;
            end
        iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        chk("n3 acc_clear", longint'(acc_clear1), 1);
        tick();
        chk("n3 k0 a_col", longint'(acol1), 64'h000001);
        chk("n3 k0 b_row", longint'(brow1), 64'h000001);
        tick();
        chk("n3 k1 a_col", longint'(acol1), 64'h000000);
        chk("n3 k1 b_row", longint'(brow1), 64'h000204);
        tick();
        chk("n3 k2 a_col", longint'(acol1), 64'h000100);
        chk("n3 k2 b_row", longint'(brow1), 64'h030507);
        lat = 3;
        for (int w = 0; w < 30 && !res_valid1; w++) begin
            tick();
            lat++;
        end
        chk("n3 latency", lat, 10);
        for (int e = 0; e < 9; e++)
            chk($sformatf("n3 C[%0d]", e), longint'(cq1[e*AW +: AW]), e + 1);
        rr[1] = 1'b1;
        tick();
        rr[1] = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
